// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-2 valid/ready demultiplexer.
// Select encodings and queue depth.
package demux_pkg;
  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;
  localparam int   QDEPTH   = 2;
endpackage

// File: rtl/demux_queue.sv
// Two-entry synchronous FIFO with a delivered-word counter.
// Pops are counted here; the caller gates pop with valid.
module demux_queue
  import demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [QDEPTH];
  logic [WIDTH-1:0] mem_d [QDEPTH];
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [1:0]       occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (occ_q == 2'(QDEPTH));
  assign valid   = (occ_q != 2'd0);
  assign data    = mem_q[rd_q];
  assign count   = cnt_q;
  assign do_push = push && !full;
  assign do_pop  = pop && valid;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    occ_d = occ_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = ~wr_q;
    end
    if (do_pop) begin
      rd_d  = ~rd_q;
      cnt_d = cnt_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      occ_q <= 2'd0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      occ_q <= occ_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sync_demux.sv
// Clocked 1-to-2 demux: steers each input word into one of two
// independent 2-entry queues, each with a delivered-word counter.
module sync_demux
  import demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] out0_count,
  output logic [CNT_W-1:0] out1_count
);

  logic full0, full1;
  logic push0, push1;
  logic pop0, pop1;
  logic accept;

  // in_ready depends only on in_sel and registered fullness
  assign in_ready = (in_sel == SEL_OUT1) ? !full1 : !full0;
  assign accept   = in_valid && in_ready;
  assign push0    = accept && (in_sel == SEL_OUT0);
  assign push1    = accept && (in_sel == SEL_OUT1);
  assign pop0     = out0_valid && out0_ready;
  assign pop1     = out1_valid && out1_ready;

  demux_queue #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_q0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push0),
    .din   (in_data),
    .full  (full0),
    .pop   (pop0),
    .valid (out0_valid),
    .data  (out0_data),
    .count (out0_count)
  );

  demux_queue #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_q1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1),
    .din   (in_data),
    .full  (full1),
    .pop   (pop1),
    .valid (out1_valid),
    .data  (out1_data),
    .count (out1_count)
  );

endmodule

// File: tb/tb_sync_demux.sv
// Randomized and directed bench for sync_demux against a
// queue-based reference model.
module tb_sync_demux;
  localparam int W = 4;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_sel = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out0_data, out1_data;
  logic         out0_valid, out1_valid;
  logic         out0_ready = 1'b0;
  logic         out1_ready = 1'b0;
  logic [C-1:0] out0_count, out1_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];
  int c0 = 0;
  int c1 = 0;

  sync_demux #(.WIDTH(W), .CNT_W(C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out0_count (out0_count),
    .out1_count (out1_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs();
    chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
    chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
    if (q0.size() != 0) chk("out0_data", 32'(out0_data), 32'(q0[0]));
    if (q1.size() != 0) chk("out1_data", 32'(out1_data), 32'(q1[0]));
    chk("out0_count", 32'(out0_count), 32'(c0));
    chk("out1_count", 32'(out1_count), 32'(c1));
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    c0 = 0;
    c1 = 0;
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic step(bit v, bit s, logic [W-1:0] d, bit r0, bit r1);
    bit room, acc, p0, p1;
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    room = s ? (q1.size() < 2) : (q0.size() < 2);
    chk("in_ready", 32'(in_ready), 32'(room));
    acc = v && room;
    p0  = r0 && (q0.size() > 0);
    p1  = r1 && (q1.size() > 0);
    @(posedge clk);
    if (p0) begin
      void'(q0.pop_front());
      c0 = (c0 + 1) % (1 << C);
    end
    if (p1) begin
      void'(q1.pop_front());
      c1 = (c1 + 1) % (1 << C);
    end
    if (acc) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
    #1;
    check_outs();
    @(negedge clk);
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outs();
    chk("rst_out0_data", 32'(out0_data), 32'h0);
    chk("rst_out1_data", 32'(out1_data), 32'h0);
    chk("rst_in_ready0", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    in_sel = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    reset_now();

    // steering
    step(1, 0, 4'hA, 1, 1);
    step(1, 1, 4'h5, 1, 1);
    step(0, 0, 4'h0, 1, 1);
    chk("steer_c0", 32'(out0_count), 32'd1);
    chk("steer_c1", 32'(out1_count), 32'd1);

    // back-pressure isolation
    step(1, 0, 4'h1, 0, 1);
    step(1, 0, 4'h2, 0, 1);
    step(1, 0, 4'h3, 0, 1);
    step(1, 1, 4'h3, 0, 1);

    // full queue with same-cycle pop
    step(1, 0, 4'h7, 1, 1);
    step(1, 0, 4'h7, 1, 1);
    step(0, 0, 4'h0, 1, 1);
    step(0, 0, 4'h0, 1, 1);
    chk("full_pop_c0", 32'(out0_count), 32'd4);

    // continuous stream to out1
    for (int i = 0; i < 16; i++) step(1, 1, W'(i), 0, 1);
    step(0, 1, 4'h0, 0, 1);

    // reset mid-stream with out0 loaded
    step(1, 0, 4'h9, 0, 0);
    step(1, 0, 4'hB, 0, 0);
    #2;
    reset_now();

    // random traffic
    for (int i = 0; i < 600; i++)
      step(bit'($urandom), bit'($urandom), W'($urandom),
           ($urandom % 4) != 0, ($urandom % 3) != 0);

    // counter wrap
    @(negedge clk);
    reset_now();
    for (int i = 0; i < 257; i++) step(1, 0, W'(i), 1, 0);
    step(0, 0, 4'h0, 1, 0);
    chk("wrap_c0", 32'(out0_count), 32'd1);
    chk("wrap_c1", 32'(out1_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
